fir_tap_scheduler: RTL and testbench



---
 rtl/fir_tap_scheduler.sv | 97 +++++++++
 tb/tb_fir_tap_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_scheduler.sv
// rtl/fir_tap_scheduler.sv - 6-tap FIR built from one shared multiplier and an accumulator
module fir_tap_scheduler #(
   parameter int W     = 16,
   parameter int CW    = 16,
   parameter int TAPS  = 6,
   parameter int ACC_W = W + CW + 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [W-1:0]     in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   input  logic                    cfg_we,
   input  logic [2:0]              cfg_addr,
   input  logic signed [CW-1:0]    cfg_data,
   output logic                    cfg_err,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                  state;
   logic signed [W-1:0]     dline [TAPS];
   logic signed [CW-1:0]    coef  [TAPS];
   logic signed [ACC_W-1:0] acc;
   logic [2:0]              k;

   logic signed [W+CW-1:0]  prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    coef_ok;

   assign prod     = coef[k] * dline[k];
   assign prod_ext = {{(ACC_W-W-CW){prod[W+CW-1]}}, prod};
   assign acc_sum  = acc + prod_ext;

   // Coefficients are frozen outside IDLE so a running sum never mixes banks.
   assign coef_ok  = cfg_we && (state == IDLE) && (cfg_addr < 3'(TAPS));

   // Decoded from the state register only; low while reset is held.
   assign in_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         out_data  <= '0;
         k         <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            dline[i] <= '0;
            coef[i]  <= '0;
         end
      end else begin
         cfg_err <= cfg_we && !coef_ok;
         if (coef_ok)
            coef[cfg_addr] <= cfg_data;

         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = TAPS - 1; i > 0; i--)
                     dline[i] <= dline[i-1];
                  dline[0] <= in_data;
                  acc      <= '0;
                  k        <= '0;
                  busy     <= 1'b1;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= acc_sum;
               k   <= k + 3'd1;
               if (k == 3'(TAPS - 1)) begin
                  out_data  <= acc_sum;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb/tb_fir_tap_scheduler.sv - directed vector bench for fir_tap_scheduler
module tb_fir_tap_scheduler;
   localparam int W = 16, CW = 16, TAPS = 6, ACC_W = W + CW + 3;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid, in_ready, out_valid, out_ready;
   logic signed [W-1:0]     in_data;
   logic signed [ACC_W-1:0] out_data;
   logic                    cfg_we, cfg_err, busy;
   logic [2:0]              cfg_addr;
   logic signed [CW-1:0]    cfg_data;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      longint x;
      longint exp;
   } vec_t;

   vec_t   vecs [14];
   longint dm [TAPS];
   longint cm [TAPS];
   longint stream_exp [10];

   fir_tap_scheduler #(.W(W), .CW(CW), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_err(cfg_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input logic [2:0] a, input longint v);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = CW'(v);
      step();
      cfg_we = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic send(input string name, input longint x, input longint exp);
      int lat;
      for (int i = 0; i < 20 && !in_ready; i++) step();
      check({name, " in_ready"}, in_ready, 1);
      in_valid = 1'b1; in_data = W'(x);
      step();
      in_valid = 1'b0;
      wait_out(lat);
      check({name, " latency"}, lat, 7);
      check({name, " data"}, out_data, exp);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, " ready_again"}, in_ready, 1);
   endtask

   initial begin
      int lat, si, ri, cyc, last;
      logic acc_now;

      // impulse response with c = 1..6, then extreme-value sweep
      for (int i = 0; i < 7; i++) vecs[i] = '{x: (i == 0) ? 1 : 0, exp: (i < 6) ? i + 1 : 0};
      for (int i = 0; i < 6; i++) vecs[7 + i] = '{x: -32768, exp: longint'(i + 1) * 1073741824};
      vecs[13] = '{x: -32768, exp: 64'sd4295000064};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      #1;
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst cfg_err", cfg_err, 0);
      check("rst out_data", out_data, 0);
      step(); step();
      rst = 1'b0;
      step();
      check("post_rst in_ready", in_ready, 1);

      for (int i = 0; i < TAPS; i++) write_coef(3'(i), i + 1);
      for (int i = 0; i < 7; i++) send($sformatf("impulse%0d", i), vecs[i].x, vecs[i].exp);
      for (int i = 0; i < TAPS; i++) write_coef(3'(i), -32768);
      for (int i = 7; i < 13; i++) send($sformatf("extreme%0d", i - 7), vecs[i].x, vecs[i].exp);
      write_coef(3'd0, 32767);
      send("extreme_mixed", vecs[13].x, vecs[13].exp);

      // backpressure: result held, in_valid during stall ignored
      for (int i = 0; i < TAPS; i++) write_coef(3'(i), i + 1);
      in_valid = 1'b1; in_data = 16'sd10;
      step();
      in_valid = 1'b0;
      wait_out(lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'sd999;
         check($sformatf("stall%0d out_valid", i), out_valid, 1);
         check($sformatf("stall%0d out_data", i), out_data, -655350);
         check($sformatf("stall%0d in_ready", i), in_ready, 0);
         step();
      end
      in_valid = 1'b0;
      check("stall end out_data", out_data, -655350);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      send("bp_next", 3, -589801);

      // coefficient write during MAC is dropped
      in_valid = 1'b1; in_data = 16'sd5;
      step();
      in_valid = 1'b0;
      step();
      write_coef(3'd2, 100);
      check("busy write cfg_err", cfg_err, 1);
      step();
      check("cfg_err one pulse", cfg_err, 0);
      wait_out(lat);
      check("busy write current", out_data, -491479);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      send("busy write next", 7, -360382);
      write_coef(3'd7, 55);
      check("bad addr cfg_err", cfg_err, 1);
      send("bad addr no change", 0, -196517);

      // write and accept on the same edge: new c[0] applies immediately
      in_valid = 1'b1; in_data = 16'sd1;
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'sd2;
      step();
      in_valid = 1'b0; cfg_we = 1'b0;
      check("simul cfg_err", cfg_err, 0);
      wait_out(lat);
      check("simul latency", lat, 7);
      check("simul data", out_data, 118);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // reset in cycle 3 of a computation
      in_valid = 1'b1; in_data = 16'sd4;
      step();
      in_valid = 1'b0;
      step(); step();
      rst = 1'b1;
      #1;
      check("midrst out_valid", out_valid, 0);
      check("midrst busy", busy, 0);
      check("midrst in_ready", in_ready, 0);
      check("midrst out_data", out_data, 0);
      step();
      rst = 1'b0;
      #1;
      check("midrst release in_ready", in_ready, 1);
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) lat++;
         step();
      end
      check("midrst no out_valid", lat, 0);
      send("post midrst zero coef", 9, 0);

      // streaming against a software FIR model
      cm = '{3, -1, 4, -1, 5, -9};
      dm = '{9, 0, 0, 0, 0, 0};
      for (int i = 0; i < TAPS; i++) write_coef(3'(i), cm[i]);
      for (int n = 0; n < 10; n++) begin
         for (int t = TAPS - 1; t > 0; t--) dm[t] = dm[t-1];
         dm[0] = n + 1;
         stream_exp[n] = 0;
         for (int t = 0; t < TAPS; t++) stream_exp[n] += cm[t] * dm[t];
      end
      in_valid = 1'b1; in_data = 16'sd1; out_ready = 1'b1;
      si = 0; ri = 0; cyc = 0; last = -1;
      while (ri < 10 && cyc < 200) begin
         acc_now = in_ready && in_valid;
         if (out_valid) begin
            check($sformatf("stream%0d data", ri), out_data, stream_exp[ri]);
            if (ri > 0) check($sformatf("stream%0d period", ri), cyc - last, 8);
            last = cyc;
            ri++;
         end
         step();
         cyc++;
         if (acc_now) begin
            si++;
            if (si < 10) in_data = W'(si + 1);
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("stream result count", ri, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
